// File: rtl/apb_cmd_sequencer_pkg.sv
// Shared types and constants for the APB command sequencer: FSM states and
// peripheral select encodings.
package apb_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } seq_state_e;

  localparam logic [1:0] PSEL_IDLE = 2'd0;
  localparam logic [1:0] PSEL_GPIO = 2'd1;
  localparam logic [1:0] PSEL_UART = 2'd2;

  function automatic logic sel_is_valid(input logic [1:0] sel);
    return (sel == PSEL_GPIO) || (sel == PSEL_UART);
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; power-of-2 depth so the
// pointers wrap naturally.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO refuses the push even when the head leaves in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Host command front end for the APB bridge: queues commands, runs one
// SETUP/ACCESS transfer at a time and returns the result on a valid/ready port.
// state  | meaning
// IDLE   | waiting for a queued command
// SETUP  | one-cycle bridge setup phase
// ACCESS | penable high, waiting for pready or timeout
// RESP   | response held until the host takes it
module apb_cmd_sequencer
  import apb_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              pclk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              transfer,
  output logic              pwrite,
  output logic              penable,
  output logic [1:0]        Psel,
  output logic [ADDR_W-1:0] write_paddr,
  output logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] apb_read_data_out,
  input  logic              pready
);

  localparam int CMD_W = 1 + 2 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              transfer_q, transfer_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic [1:0]        psel_q, psel_d;
  logic [ADDR_W-1:0] write_paddr_q, write_paddr_d;
  logic [ADDR_W-1:0] read_paddr_q, read_paddr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic [CMD_W-1:0]  fifo_wdata;
  logic [CMD_W-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              head_write;
  logic [1:0]        head_sel;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              on_bus;

  assign fifo_wdata = {cmd_write, cmd_sel, cmd_addr, cmd_wdata};
  assign {head_write, head_sel, head_addr, head_wdata} = fifo_rdata;

  apb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .pclk  (pclk),
    .reset (Reset),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (sel_is_valid(head_sel)) begin
            state_d = ST_SETUP;
          end else begin
            state_d     = ST_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        // pready wins over the timeout on the final allowed cycle.
        if (pready) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = head_write ? '0 : apb_read_data_out;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          fifo_pop    = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus registers are loaded with the values for the state being entered.
    on_bus        = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    transfer_d    = on_bus;
    penable_d     = (state_d == ST_ACCESS);
    psel_d        = on_bus ? head_sel : PSEL_IDLE;
    pwrite_d      = on_bus && head_write;
    write_paddr_d = (on_bus && head_write)  ? head_addr  : '0;
    read_paddr_d  = (on_bus && !head_write) ? head_addr  : '0;
    write_data_d  = (on_bus && head_write)  ? head_wdata : '0;
  end

  always_ff @(posedge pclk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      transfer_q    <= 1'b0;
      pwrite_q      <= 1'b0;
      penable_q     <= 1'b0;
      psel_q        <= PSEL_IDLE;
      write_paddr_q <= '0;
      read_paddr_q  <= '0;
      write_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      transfer_q    <= transfer_d;
      pwrite_q      <= pwrite_d;
      penable_q     <= penable_d;
      psel_q        <= psel_d;
      write_paddr_q <= write_paddr_d;
      read_paddr_q  <= read_paddr_d;
      write_data_q  <= write_data_d;
    end
  end

  assign cmd_ready      = !fifo_full;
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign transfer       = transfer_q;
  assign pwrite         = pwrite_q;
  assign penable        = penable_q;
  assign Psel           = psel_q;
  assign write_paddr    = write_paddr_q;
  assign apb_read_paddr = read_paddr_q;
  assign write_data     = write_data_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed and randomized bench for apb_cmd_sequencer; expected bus phases and
// responses come from a cycle-indexed transaction model.
module tb_apb_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic              pclk = 1'b0;
  logic              Reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              transfer;
  logic              pwrite;
  logic              penable;
  logic [1:0]        Psel;
  logic [ADDR_W-1:0] write_paddr;
  logic [ADDR_W-1:0] apb_read_paddr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] apb_read_data_out;
  logic              pready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .pclk              (pclk),
    .Reset             (Reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_sel           (cmd_sel),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .transfer          (transfer),
    .pwrite            (pwrite),
    .penable           (penable),
    .Psel              (Psel),
    .write_paddr       (write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .write_data        (write_data),
    .apb_read_data_out (apb_read_data_out),
    .pready            (pready)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] bus_obs();
    return {transfer, penable, pwrite, Psel, write_paddr, apb_read_paddr, write_data,
            rsp_valid, cmd_ready};
  endfunction

  function automatic logic [48:0] bus_exp(input bit act, input bit acc, input logic wr,
                                          input logic [1:0] sel, input logic [4:0] addr,
                                          input logic [31:0] wd, input bit rv);
    logic [1:0]  s;
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [31:0] d;
    s  = act ? sel : 2'd0;
    wa = (act && wr)  ? addr : 5'd0;
    ra = (act && !wr) ? addr : 5'd0;
    d  = (act && wr)  ? wd   : 32'd0;
    return {act, act && acc, act && wr, s, wa, ra, d, rv, 1'b1};
  endfunction

  // One command through an otherwise empty sequencer. delay = ACCESS cycles with
  // pready low before it rises; hold = cycles the host stalls the response.
  task automatic xfer(input logic wr, input logic [1:0] sel, input logic [4:0] addr,
                      input logic [31:0] wd, input int delay, input logic [31:0] rd,
                      input int hold, input string tag);
    bit          vsel;
    bit          tmo;
    int          n;
    int          resp_t;
    logic        eerr;
    logic [31:0] erd;
    vsel   = (sel == 2'd1) || (sel == 2'd2);
    tmo    = vsel && (delay >= TIMEOUT);
    n      = !vsel ? 0 : (tmo ? TIMEOUT : delay + 1);
    resp_t = vsel ? n + 2 : 1;
    eerr   = !vsel || tmo;
    erd    = (!eerr && !wr) ? rd : 32'd0;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_sel   = sel;
    cmd_addr  = addr;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_sel   = 2'($urandom);
    cmd_addr  = 5'($urandom);
    cmd_wdata = $urandom;

    for (int t = 0; t <= resp_t; t++) begin
      bit act;
      bit acc;
      if (t > 0) tick();
      act = vsel && (t >= 1) && (t < resp_t);
      acc = act && (t >= 2);
      chk({tag, "_bus"}, 64'(bus_obs()), 64'(bus_exp(act, acc, wr, sel, addr, wd, t == resp_t)));
      if (acc) begin
        pready            = !tmo && (t == n + 1);
        apb_read_data_out = (t == n + 1) ? rd : $urandom;
      end else begin
        pready            = 1'($urandom);
        apb_read_data_out = $urandom;
      end
      rsp_ready = (t == resp_t) ? (hold == 0) : 1'($urandom);
    end
    chk({tag, "_rsp"}, 64'({rsp_err, rsp_rdata}), 64'({eerr, erd}));

    for (int h = 1; h <= hold; h++) begin
      tick();
      chk({tag, "_hold_bus"}, 64'(bus_obs()), 64'(bus_exp(0, 0, wr, sel, addr, wd, 1)));
      chk({tag, "_hold_rsp"}, 64'({rsp_err, rsp_rdata}), 64'({eerr, erd}));
      pready    = 1'($urandom);
      rsp_ready = (h == hold);
    end

    tick();
    chk({tag, "_done"}, 64'(bus_obs()), 64'(bus_exp(0, 0, wr, sel, addr, wd, 0)));
    rsp_ready = 1'b0;
    pready    = 1'b0;
  endtask

  logic        fw [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]  fs [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
  logic [32:0] exp_q [$];

  initial begin
    int got;
    Reset             = 1'b1;
    cmd_valid         = 1'b0;
    cmd_write         = 1'b0;
    cmd_sel           = 2'd0;
    cmd_addr          = '0;
    cmd_wdata         = '0;
    rsp_ready         = 1'b0;
    apb_read_data_out = '0;
    pready            = 1'b0;
    repeat (3) tick();
    chk("reset_bus", 64'(bus_obs()), 64'(bus_exp(0, 0, 0, 2'd0, 5'd0, 32'd0, 0)));
    chk("reset_rsp", 64'({rsp_err, rsp_rdata}), 64'd0);
    Reset = 1'b0;
    tick();

    xfer(1'b1, 2'd1, 5'd3, 32'hA5A5_0001, 0, 32'h0, 0, "wr_gpio");
    xfer(1'b0, 2'd2, 5'd4, 32'h0, 3, 32'h0000_0041, 1, "rd_uart");
    xfer(1'b0, 2'd1, 5'd7, 32'h0, 20, 32'hDEAD_BEEF, 0, "timeout");
    xfer(1'b1, 2'd2, 5'd12, 32'h5555_AAAA, 1, 32'h0, 0, "post_timeout");
    xfer(1'b0, 2'd2, 5'd9, 32'h0, 15, 32'h1357_9BDF, 0, "ready_last_cycle");
    xfer(1'b0, 2'd1, 5'd9, 32'h0, 16, 32'h1357_9BDF, 0, "timeout_edge");
    xfer(1'b1, 2'd0, 5'd1, 32'hFFFF_0000, 0, 32'h0, 1, "invalid_sel0");
    xfer(1'b0, 2'd3, 5'd2, 32'h0, 0, 32'h1111_1111, 0, "invalid_sel3");

    // Fill with the host stalled, then drain in order.
    pready            = 1'b1;
    apb_read_data_out = 32'h0000_1234;
    rsp_ready         = 1'b0;
    exp_q = '{33'h0_0000_0000, 33'h1_0000_0000, 33'h0_0000_1234, 33'h1_0000_0000};
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_write = fw[i];
      cmd_sel   = fs[i];
      cmd_addr  = 5'(i + 1);
      cmd_wdata = 32'(i + 32'h100);
      chk("fill_ready_pre", 64'(cmd_ready), 64'(i < 4));
      tick();
    end
    cmd_valid = 1'b0;
    chk("fill_ready_post", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      if (rsp_valid) begin
        got++;
        if (exp_q.size() > 0) chk("fill_rsp", 64'({rsp_err, rsp_rdata}), 64'(exp_q.pop_front()));
        else chk("fill_extra_rsp", 64'(rsp_valid), 64'd0);
      end
      tick();
    end
    chk("fill_rsp_count", 64'(got), 64'd4);
    chk("fill_ready_end", 64'(cmd_ready), 64'd1);
    rsp_ready = 1'b0;
    pready    = 1'b0;

    // Randomized commands against the transaction model.
    for (int i = 0; i < 40; i++) begin
      int          r;
      int          dly;
      logic [1:0]  sel;
      r   = int'($urandom_range(0, 9));
      sel = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
      dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20))
                                        : int'($urandom_range(0, 5));
      xfer(1'($urandom), sel, 5'($urandom), $urandom, dly, $urandom,
           int'($urandom_range(0, 2)), "random");
    end

    // Reset in the middle of ACCESS with a second command queued.
    pready    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_sel   = 2'd1;
    cmd_addr  = 5'd6;
    tick();
    cmd_sel  = 2'd2;
    cmd_addr = 5'd8;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_pre_access", 64'(penable), 64'd1);
    Reset = 1'b1;
    tick();
    chk("rst_mid_bus", 64'(bus_obs()), 64'(bus_exp(0, 0, 0, 2'd0, 5'd0, 32'd0, 0)));
    chk("rst_mid_rsp", 64'({rsp_err, rsp_rdata}), 64'd0);
    Reset     = 1'b0;
    pready    = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_queue_lost", 64'(bus_obs()), 64'(bus_exp(0, 0, 0, 2'd0, 5'd0, 32'd0, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
